// File: rtl/avst_video_frame_parser.sv
// Avalon-ST Video sink-side parser: decodes control packets into the active
// frame geometry, strips packet headers and forwards video payload pixels with
// start-of-frame / end-of-line / end-of-frame markers and length checking.
module avst_video_frame_parser #(
    parameter int BITS_PER_SYMBOL = 8,
    parameter int WIDTH           = 800,
    parameter int HEIGHT          = 600,
    localparam int DATA_W         = BITS_PER_SYMBOL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [DATA_W-1:0] din_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_sof,
    output logic              dout_eol,
    output logic              dout_eof,
    output logic [15:0]       width_o,
    output logic [15:0]       height_o,
    output logic [3:0]        interlaced_o,
    output logic              ctrl_update_o,
    output logic              err_ctrl_o,
    output logic              err_short_o,
    output logic              err_long_o
);

    typedef enum logic [1:0] {
        IDLE,
        CTRL,
        VIDEO,
        DISCARD
    } state_t;

    localparam logic [3:0] TYPE_VIDEO = 4'h0;
    localparam logic [3:0] TYPE_CTRL  = 4'hF;

    state_t      state;
    logic [15:0] x_cnt;
    logic [15:0] y_cnt;
    logic [15:0] vid_w;
    logic [15:0] vid_h;
    logic        frame_done;
    logic        long_seen;
    logic [3:0]  nib_cnt;
    logic [15:0] shadow_w;
    logic [15:0] shadow_h;
    logic [3:0]  shadow_i;

    logic [3:0]  nib_cnt_nxt;
    logic [15:0] shadow_w_nxt;
    logic [15:0] shadow_h_nxt;
    logic [3:0]  shadow_i_nxt;
    logic        ctrl_ok;
    logic [3:0]  hdr_type;
    logic        beat_ok;
    logic        x_last;
    logic        y_last;

    assign hdr_type = din_data[3:0];
    assign x_last   = (x_cnt == vid_w - 16'd1);
    assign y_last   = (y_cnt == vid_h - 16'd1);

    // Excess pixels after end of frame are swallowed even while the output is stalled.
    assign din_ready = (state != VIDEO) || frame_done || !dout_valid || dout_ready;
    assign beat_ok   = din_valid && din_ready;

    // Shift the incoming nibble into the control shadow registers (width, height, interlace).
    always_comb begin
        shadow_w_nxt = shadow_w;
        shadow_h_nxt = shadow_h;
        shadow_i_nxt = shadow_i;
        nib_cnt_nxt  = nib_cnt;
        if (nib_cnt < 4'd4) begin
            shadow_w_nxt = {shadow_w[11:0], din_data[3:0]};
        end else if (nib_cnt < 4'd8) begin
            shadow_h_nxt = {shadow_h[11:0], din_data[3:0]};
        end else if (nib_cnt == 4'd8) begin
            shadow_i_nxt = din_data[3:0];
        end
        if (nib_cnt < 4'd9) begin
            nib_cnt_nxt = nib_cnt + 4'd1;
        end
        ctrl_ok = (nib_cnt_nxt == 4'd9) && (shadow_w_nxt != 16'd0) && (shadow_h_nxt != 16'd0);
    end

    // Packet state machine, pixel position counters, output register and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            x_cnt         <= 16'd0;
            y_cnt         <= 16'd0;
            vid_w         <= 16'(WIDTH);
            vid_h         <= 16'(HEIGHT);
            frame_done    <= 1'b0;
            long_seen     <= 1'b0;
            nib_cnt       <= 4'd0;
            shadow_w      <= 16'd0;
            shadow_h      <= 16'd0;
            shadow_i      <= 4'd0;
            dout_valid    <= 1'b0;
            dout_data     <= '0;
            dout_sof      <= 1'b0;
            dout_eol      <= 1'b0;
            dout_eof      <= 1'b0;
            width_o       <= 16'(WIDTH);
            height_o      <= 16'(HEIGHT);
            interlaced_o  <= 4'd0;
            ctrl_update_o <= 1'b0;
            err_ctrl_o    <= 1'b0;
            err_short_o   <= 1'b0;
            err_long_o    <= 1'b0;
        end else begin
            ctrl_update_o <= 1'b0;
            err_ctrl_o    <= 1'b0;
            err_short_o   <= 1'b0;
            err_long_o    <= 1'b0;

            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
                dout_sof   <= 1'b0;
                dout_eol   <= 1'b0;
                dout_eof   <= 1'b0;
            end

            if (beat_ok) begin
                if (din_sop) begin
                    if (state == CTRL) begin
                        err_ctrl_o <= 1'b1;
                    end
                    if (state == VIDEO && !frame_done) begin
                        err_short_o <= 1'b1;
                    end
                    x_cnt      <= 16'd0;
                    y_cnt      <= 16'd0;
                    nib_cnt    <= 4'd0;
                    frame_done <= 1'b0;
                    long_seen  <= 1'b0;
                    vid_w      <= width_o;
                    vid_h      <= height_o;
                    if (din_eop) begin
                        state <= IDLE;
                        if (hdr_type == TYPE_VIDEO) begin
                            err_short_o <= 1'b1;
                        end
                        if (hdr_type == TYPE_CTRL) begin
                            err_ctrl_o <= 1'b1;
                        end
                    end else if (hdr_type == TYPE_VIDEO) begin
                        state <= VIDEO;
                    end else if (hdr_type == TYPE_CTRL) begin
                        state <= CTRL;
                    end else begin
                        state <= DISCARD;
                    end
                end else begin
                    case (state)
                        CTRL: begin
                            nib_cnt  <= nib_cnt_nxt;
                            shadow_w <= shadow_w_nxt;
                            shadow_h <= shadow_h_nxt;
                            shadow_i <= shadow_i_nxt;
                            if (din_eop) begin
                                state <= IDLE;
                                if (ctrl_ok) begin
                                    width_o       <= shadow_w_nxt;
                                    height_o      <= shadow_h_nxt;
                                    interlaced_o  <= shadow_i_nxt;
                                    ctrl_update_o <= 1'b1;
                                end else begin
                                    err_ctrl_o <= 1'b1;
                                end
                            end
                        end
                        VIDEO: begin
                            if (!frame_done) begin
                                dout_valid <= 1'b1;
                                dout_data  <= din_data;
                                dout_sof   <= (x_cnt == 16'd0) && (y_cnt == 16'd0);
                                dout_eol   <= x_last;
                                dout_eof   <= x_last && y_last;
                                if (x_last) begin
                                    x_cnt <= 16'd0;
                                    y_cnt <= y_cnt + 16'd1;
                                    if (y_last) begin
                                        frame_done <= 1'b1;
                                    end
                                end else begin
                                    x_cnt <= x_cnt + 16'd1;
                                end
                                if (din_eop && !(x_last && y_last)) begin
                                    err_short_o <= 1'b1;
                                end
                            end else if (!long_seen) begin
                                err_long_o <= 1'b1;
                                long_seen  <= 1'b1;
                            end
                            if (din_eop) begin
                                state <= IDLE;
                            end
                        end
                        DISCARD: begin
                            if (din_eop) begin
                                state <= IDLE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_avst_video_frame_parser.sv
// Directed testbench for avst_video_frame_parser: control parsing, video
// framing markers, short/long packet detection, back-pressure and reset.
module tb_avst_video_frame_parser;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic [7:0]  din_data = 8'h00;
    logic        dout_valid;
    logic        dout_ready;
    logic [7:0]  dout_data;
    logic        dout_sof;
    logic        dout_eol;
    logic        dout_eof;
    logic [15:0] width_o;
    logic [15:0] height_o;
    logic [3:0]  interlaced_o;
    logic        ctrl_update_o;
    logic        err_ctrl_o;
    logic        err_short_o;
    logic        err_long_o;

    int    checks = 0;
    int    errors = 0;
    int    ready_mode = 0;
    logic  hung = 1'b0;

    beat_t q[$];
    int    n_upd = 0;
    int    n_ectrl = 0;
    int    n_short = 0;
    int    n_long = 0;
    int    stab_err = 0;
    logic  prev_stalled = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [2:0] prev_flags = 3'b000;

    avst_video_frame_parser #(
        .BITS_PER_SYMBOL(8),
        .WIDTH(800),
        .HEIGHT(600)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .din_sop(din_sop),
        .din_eop(din_eop),
        .din_data(din_data),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_data(dout_data),
        .dout_sof(dout_sof),
        .dout_eol(dout_eol),
        .dout_eof(dout_eof),
        .width_o(width_o),
        .height_o(height_o),
        .interlaced_o(interlaced_o),
        .ctrl_update_o(ctrl_update_o),
        .err_ctrl_o(err_ctrl_o),
        .err_short_o(err_short_o),
        .err_long_o(err_long_o)
    );

    // 10-unit clock period.
    initial forever #5 clk = ~clk;

    // Downstream ready: always on, random 50%, or held off, chosen by ready_mode.
    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: record transferred pixels, count pulses, watch stalled outputs for stability.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            prev_stalled = 1'b0;
        end else begin
            if (prev_stalled && (dout_valid !== 1'b1 || dout_data !== prev_data ||
                                 {dout_sof, dout_eol, dout_eof} !== prev_flags)) begin
                stab_err++;
            end
            if (dout_valid && dout_ready) begin
                b.data = dout_data;
                b.sof  = dout_sof;
                b.eol  = dout_eol;
                b.eof  = dout_eof;
                q.push_back(b);
            end
            if (ctrl_update_o) n_upd++;
            if (err_ctrl_o)    n_ectrl++;
            if (err_short_o)   n_short++;
            if (err_long_o)    n_long++;
            prev_stalled = dout_valid && !dout_ready;
            prev_data    = dout_data;
            prev_flags   = {dout_sof, dout_eol, dout_eof};
        end
    end

    // Hard stop in case the sequence itself stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before end of sequence");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic sop, input logic eop, input logic [7:0] data, output int waits);
        logic acc;
        waits = 0;
        if (!hung) begin
            din_valid = 1'b1;
            din_sop   = sop;
            din_eop   = eop;
            din_data  = data;
            acc       = 1'b0;
            while (!acc && !hung) begin
                @(negedge clk);
                acc = din_ready;
                @(posedge clk);
                #1;
                if (!acc) begin
                    waits++;
                    if (waits > 1000) hung = 1'b1;
                end
            end
            din_valid = 1'b0;
            din_sop   = 1'b0;
            din_eop   = 1'b0;
        end
    endtask

    task automatic send_ctrl(input logic [35:0] nibs, input int count);
        int wt;
        apply_stimulus(1'b1, 1'b0, 8'hCF, wt);
        for (int i = 0; i < count; i++) begin
            apply_stimulus(1'b0, i == count - 1, {4'hC, nibs[35-4*i -: 4]}, wt);
        end
    endtask

    task automatic send_video(input int n, input logic [7:0] seed, input logic with_eop,
                              input int stall_at, output int waits_all, output int waits_excess);
        int wt;
        apply_stimulus(1'b1, 1'b0, 8'h50, wt);
        waits_all    = wt;
        waits_excess = 0;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) ready_mode = 2;
            apply_stimulus(1'b0, with_eop && (i == n - 1), seed + 8'(i), wt);
            waits_all += wt;
            if (stall_at >= 0 && i >= stall_at) waits_excess += wt;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int base, input int n_exp,
                               input int w, input int h, input logic [7:0] seed);
        int n_got;
        int bad_data;
        int bad_flag;
        int x;
        int y;
        logic [7:0] exp_data;
        n_got    = q.size() - base;
        bad_data = 0;
        bad_flag = 0;
        check_output({tag, "_beats"}, 32'(n_got), 32'(n_exp));
        for (int k = 0; k < n_got && k < n_exp; k++) begin
            x        = k % w;
            y        = k / w;
            exp_data = seed + 8'(k);
            if (q[base+k].data !== exp_data) bad_data++;
            if (q[base+k].sof !== (k == 0) ||
                q[base+k].eol !== (x == w - 1) ||
                q[base+k].eof !== (x == w - 1 && y == h - 1)) bad_flag++;
        end
        check_output({tag, "_data_errs"}, 32'(bad_data), 32'd0);
        check_output({tag, "_flag_errs"}, 32'(bad_flag), 32'd0);
    endtask

    // Linear directed sequence.
    initial begin
        int base;
        int s_upd;
        int s_ectrl;
        int s_short;
        int s_long;
        int s_stab;
        int wa;
        int we;
        int wt;

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] reset values");
        check_output("rst_dout_valid", 32'(dout_valid), 32'd0);
        check_output("rst_dout_data", 32'(dout_data), 32'd0);
        check_output("rst_width", 32'(width_o), 32'd800);
        check_output("rst_height", 32'(height_o), 32'd600);
        check_output("rst_interlaced", 32'(interlaced_o), 32'd0);
        check_output("rst_din_ready", 32'(din_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        $display("[TB] control packet 64x48");
        s_upd = n_upd; s_ectrl = n_ectrl;
        send_ctrl(36'h004000300, 9);
        idle_cycles(3);
        check_output("ctrl_width", 32'(width_o), 32'd64);
        check_output("ctrl_height", 32'(height_o), 32'd48);
        check_output("ctrl_interlaced", 32'(interlaced_o), 32'd0);
        check_output("ctrl_update_pulses", 32'(n_upd - s_upd), 32'd1);
        check_output("ctrl_err_pulses", 32'(n_ectrl - s_ectrl), 32'd0);

        $display("[TB] full frame at full throughput");
        base = q.size(); s_short = n_short; s_long = n_long; s_ectrl = n_ectrl;
        send_video(3072, 8'h11, 1'b1, -1, wa, we);
        idle_cycles(5);
        check_frame("full", base, 3072, 64, 48, 8'h11);
        check_output("full_input_waits", 32'(wa), 32'd0);
        check_output("full_err_short", 32'(n_short - s_short), 32'd0);
        check_output("full_err_long", 32'(n_long - s_long), 32'd0);
        check_output("full_err_ctrl", 32'(n_ectrl - s_ectrl), 32'd0);

        $display("[TB] short packet of 100 pixels");
        base = q.size(); s_short = n_short;
        send_video(100, 8'h3A, 1'b1, -1, wa, we);
        idle_cycles(5);
        check_frame("short", base, 100, 64, 48, 8'h3A);
        check_output("short_err_short", 32'(n_short - s_short), 32'd1);

        $display("[TB] long packet of 3080 pixels, output held during excess");
        base = q.size(); s_short = n_short; s_long = n_long;
        send_video(3080, 8'h77, 1'b1, 3072, wa, we);
        ready_mode = 0;
        idle_cycles(5);
        check_frame("long", base, 3072, 64, 48, 8'h77);
        check_output("long_excess_waits", 32'(we), 32'd0);
        check_output("long_err_long", 32'(n_long - s_long), 32'd1);
        check_output("long_err_short", 32'(n_short - s_short), 32'd0);

        $display("[TB] rejected control packets");
        s_upd = n_upd; s_ectrl = n_ectrl;
        send_ctrl(36'h004000300, 5);
        idle_cycles(2);
        check_output("ctrl_trunc_err", 32'(n_ectrl - s_ectrl), 32'd1);
        send_ctrl(36'h000000300, 9);
        idle_cycles(3);
        check_output("ctrl_rej_err", 32'(n_ectrl - s_ectrl), 32'd2);
        check_output("ctrl_rej_update", 32'(n_upd - s_upd), 32'd0);
        check_output("ctrl_rej_width", 32'(width_o), 32'd64);
        check_output("ctrl_rej_height", 32'(height_o), 32'd48);

        $display("[TB] full frame with random back-pressure");
        base = q.size(); s_short = n_short; s_long = n_long; s_stab = stab_err;
        ready_mode = 1;
        send_video(3072, 8'hC4, 1'b1, -1, wa, we);
        ready_mode = 0;
        idle_cycles(10);
        check_frame("stall", base, 3072, 64, 48, 8'hC4);
        check_output("stall_stability_errs", 32'(stab_err - s_stab), 32'd0);
        check_output("stall_err_short", 32'(n_short - s_short), 32'd0);
        check_output("stall_err_long", 32'(n_long - s_long), 32'd0);

        $display("[TB] video abandoned by new header, then zero-pixel video");
        base = q.size(); s_short = n_short; s_long = n_long; s_ectrl = n_ectrl;
        send_video(10, 8'h20, 1'b0, -1, wa, we);
        apply_stimulus(1'b1, 1'b0, 8'h35, wt);
        apply_stimulus(1'b0, 1'b0, 8'hAA, wt);
        apply_stimulus(1'b0, 1'b1, 8'hBB, wt);
        idle_cycles(2);
        check_output("abandon_err_short", 32'(n_short - s_short), 32'd1);
        apply_stimulus(1'b1, 1'b1, 8'h00, wt);
        idle_cycles(3);
        check_frame("abandon", base, 10, 64, 48, 8'h20);
        check_output("zero_pix_err_short", 32'(n_short - s_short), 32'd2);
        check_output("abandon_err_ctrl", 32'(n_ectrl - s_ectrl), 32'd0);
        check_output("abandon_err_long", 32'(n_long - s_long), 32'd0);

        $display("[TB] reset mid-frame");
        send_video(20, 8'h60, 1'b0, -1, wa, we);
        din_valid = 1'b1;
        din_data  = 8'hEE;
        rst       = 1'b1;
        @(negedge clk);
        check_output("pre_reset_valid", 32'(dout_valid), 32'd1);
        @(posedge clk);
        #1;
        check_output("post_reset_valid", 32'(dout_valid), 32'd0);
        check_output("post_reset_width", 32'(width_o), 32'd800);
        check_output("post_reset_height", 32'(height_o), 32'd600);
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);
        base = q.size();
        wa = 0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, i == 3, 8'h90 + 8'(i), wt);
            wa += wt;
        end
        idle_cycles(3);
        check_output("no_sop_beats", 32'(q.size() - base), 32'd0);
        check_output("no_sop_waits", 32'(wa), 32'd0);

        $display("[TB] tiny interlaced frame 4x2");
        s_upd = n_upd; s_short = n_short; s_long = n_long;
        send_ctrl(36'h000400021, 9);
        idle_cycles(3);
        check_output("tiny_width", 32'(width_o), 32'd4);
        check_output("tiny_height", 32'(height_o), 32'd2);
        check_output("tiny_interlaced", 32'(interlaced_o), 32'd1);
        check_output("tiny_update", 32'(n_upd - s_upd), 32'd1);
        base = q.size();
        send_video(8, 8'hF0, 1'b1, -1, wa, we);
        idle_cycles(4);
        check_frame("tiny", base, 8, 4, 2, 8'hF0);
        check_output("tiny_err_short", 32'(n_short - s_short), 32'd0);
        check_output("tiny_err_long", 32'(n_long - s_long), 32'd0);

        check_output("input_not_hung", 32'(hung), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avst_video_frame_parser.md
Name: avst_video_frame_parser

Overview:
- Sink-side companion that consumes the Avalon-ST Video stream produced by the clocked-video-input path: control packets, video packets and other packets, each carrying its type in the first beat.
- Parses control packets into active frame geometry (width/height/interlaced) and strips packet headers.
- Forwards video payload pixels with frame/line markers and checks each video packet's length against that geometry.
- Feeds pixel-oriented consumers (framebuffer writer, scaler) that need line/frame position rather than packet framing.

Parameters:
- BITS_PER_SYMBOL, 8, symbol width; data width DATA_W = BITS_PER_SYMBOL (one symbol per beat only).
- WIDTH, 800, default active width used until the first valid control packet.
- HEIGHT, 600, default active height used until the first valid control packet.

Ports:
- clk, input, 1, single clock for all logic.
- rst, input, 1, synchronous active-high reset.
- din_valid, input, 1, Avalon-ST sink valid.
- din_ready, output, 1, Avalon-ST sink ready.
- din_sop, input, 1, start of packet (header beat).
- din_eop, input, 1, end of packet.
- din_data, input, DATA_W, packet data; header type is in [3:0].
- dout_valid, output, 1, pixel valid.
- dout_ready, input, 1, downstream ready.
- dout_data, output, DATA_W, pixel data.
- dout_sof, output, 1, first pixel of frame (x=0, y=0).
- dout_eol, output, 1, last pixel of line (x=width-1).
- dout_eof, output, 1, last pixel of frame (x=width-1, y=height-1).
- width_o, output, 16, active width.
- height_o, output, 16, active height.
- interlaced_o, output, 4, active interlace nibble.
- ctrl_update_o, output, 1, one-cycle pulse when geometry is updated.
- err_ctrl_o, output, 1, one-cycle pulse when a control packet is rejected.
- err_short_o, output, 1, one-cycle pulse when a video packet ends before width*height pixels.
- err_long_o, output, 1, one-cycle pulse on the first pixel beyond width*height.

Behaviour:
- Reset values:
  - dout_valid, dout_sof, dout_eol, dout_eof, ctrl_update_o and all err_* are 0; dout_data is 0.
  - width_o=WIDTH, height_o=HEIGHT, interlaced_o=0.
  - State is IDLE and the x/y/nibble counters are 0.
- A beat is accepted when din_valid & din_ready.
- din_ready is 1 in IDLE, CTRL and DISCARD, and in VIDEO while the pixel is being dropped as excess.
- In VIDEO otherwise, din_ready = ~dout_valid | dout_ready.
- Output stage is a single register; latency from input acceptance to dout_valid is 1 cycle. dout_valid, dout_data and the flags hold until dout_ready.
- A sop beat in any state is a header. Header type 0 -> VIDEO; 0xF -> CTRL; any other type -> DISCARD.
- A sop arriving mid-packet abandons the current packet:
  - In CTRL the update is dropped and err_ctrl_o pulses.
  - In VIDEO err_short_o pulses if the count is incomplete.
- A header with eop -> IDLE. A type-0 header with eop is a zero-pixel video packet and pulses err_short_o.
- IDLE: non-sop beats are accepted and dropped.
- CTRL:
  - Accepted beats 0..8 load nibble din_data[3:0] into shadow registers: beats 0-3 = width[15:12]..[3:0], beats 4-7 = height[15:12]..[3:0], beat 8 = interlaced.
  - On the eop beat, if all 9 nibbles were received and shadow width != 0 and height != 0: copy to width_o/height_o/interlaced_o and pulse ctrl_update_o the next cycle.
  - Otherwise keep the old values and pulse err_ctrl_o.
  - Beats after nibble 8 are ignored. -> IDLE.
- VIDEO:
  - Geometry is sampled at the header; updates affect the next frame only.
  - Each forwarded pixel carries sof = (x==0 && y==0), eol = (x==w-1), eof = (x==w-1 && y==h-1).
  - x wraps to 0 at w-1 and y increments.
  - Excess pixels (after eof) are consumed and not forwarded; err_long_o pulses once per packet.
  - eop before eof: the pixel is forwarded as normal, err_short_o pulses, then -> IDLE.
  - eop on or after eof -> IDLE.
- DISCARD: all beats are consumed until eop -> IDLE.
- Counters are 16-bit unsigned; comparisons use the geometry sampled at the header.
- Reset mid-packet returns to IDLE with the reset values. Stream input is discarded until the next sop.

Test Plan:
- Control packet type 0xF with nibbles 0,0,4,0, 0,0,3,0, 0 -> width_o=64, height_o=48, interlaced_o=0, one ctrl_update_o pulse.
- Video packet of 64*48 pixels at full throughput -> 3072 dout beats; dout_sof on beat 0; dout_eol every 64th beat; dout_eof on beat 3071; no err_* pulses.
- Video packet ending after 100 pixels (w=64) -> 100 beats forwarded, err_short_o pulses once, next header parsed normally.
- Video packet of 3080 pixels -> 3072 forwarded, err_long_o pulses once, 8 beats dropped with din_ready=1.
- Control packet with eop after 5 nibbles, then a width=0 control packet -> two err_ctrl_o pulses, geometry unchanged at 64x48.
- Random dout_ready deassertion over 50% of cycles during a video packet -> no data loss or duplication, output order preserved, dout_* held stable while stalled; reset asserted mid-frame -> dout_valid=0 the next cycle.
